// File: rtl/pid_avg_filter.sv
// pid_avg_filter
//   Moving-average stage of the PID error path. Holds a sliding window of the
//   last DEPTH signed error samples and, on request, sums them serially (one
//   sample per clock through a single adder) and divides by DEPTH with an
//   arithmetic right shift, i.e. floor toward minus infinity.
//
// Ports
//   clk        in   system clock, rising edge
//   n_rst      in   asynchronous active-low reset
//   shift_avg  in   one-cycle pulse: push error_in into the window (IDLE only)
//   calc_avg   in   one-cycle pulse: start an average (IDLE only)
//   clr_hist   in   zero the whole window on the next edge (IDLE only)
//   error_in   in   signed two's-complement error sample
//   avg_out    out  signed window mean, held until the next result
//   avg_done   out  one-cycle pulse while avg_out is freshly updated
//   busy       out  high while a sum is in progress (SUM or DONE)
//   overrun    out  one-cycle pulse: a command arrived while busy and was dropped

module pid_avg_filter #(
    parameter int DATA_W     = 12,
    parameter int DEPTH      = 8,
    parameter int LOG2_DEPTH = 3
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              shift_avg,
    input  logic              calc_avg,
    input  logic              clr_hist,
    input  logic [DATA_W-1:0] error_in,
    output logic [DATA_W-1:0] avg_out,
    output logic              avg_done,
    output logic              busy,
    output logic              overrun
);

    // DEPTH samples of DATA_W bits sum into DATA_W+LOG2_DEPTH bits without overflow.
    localparam int ACC_W = DATA_W + LOG2_DEPTH;
    localparam logic [LOG2_DEPTH-1:0] IDX_LAST = LOG2_DEPTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUM  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [LOG2_DEPTH-1:0]     idx_q, idx_d;
    logic signed [DATA_W-1:0]  avg_out_q, avg_out_d;
    logic                      overrun_q, overrun_d;
    logic signed [DATA_W-1:0]  hist_q [DEPTH];
    logic signed [DATA_W-1:0]  hist_d [DEPTH];

    logic any_cmd;

    function automatic logic signed [ACC_W-1:0] sign_ext(input logic signed [DATA_W-1:0] s);
        return {{LOG2_DEPTH{s[DATA_W-1]}}, s};
    endfunction

    // Divide by DEPTH via arithmetic shift (floor). The mean of DATA_W-bit
    // samples always fits back into DATA_W, so truncation drops only sign copies.
    function automatic logic signed [DATA_W-1:0] div_window(input logic signed [ACC_W-1:0] sum);
        return DATA_W'(sum >>> LOG2_DEPTH);
    endfunction

    assign any_cmd = shift_avg | calc_avg | clr_hist;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        avg_out_d = avg_out_q;
        overrun_d = 1'b0;
        hist_d    = hist_q;

        unique case (state_q)
            IDLE: begin
                // Clear has priority over a simultaneous shift.
                if (clr_hist) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        hist_d[k] = '0;
                    end
                end else if (shift_avg) begin
                    hist_d[0] = $signed(error_in);
                    for (int k = 1; k < DEPTH; k++) begin
                        hist_d[k] = hist_q[k-1];
                    end
                end
                // A shift on the same edge lands before SUM reads hist[0].
                if (calc_avg) begin
                    state_d = SUM;
                    acc_d   = '0;
                    idx_d   = '0;
                end
            end

            SUM: begin
                acc_d     = acc_q + sign_ext(hist_q[idx_q]);
                idx_d     = idx_q + 1'b1;
                overrun_d = any_cmd;
                if (idx_q == IDX_LAST) begin
                    state_d   = DONE;
                    avg_out_d = div_window(acc_d);
                end
            end

            DONE: begin
                state_d   = IDLE;
                overrun_d = any_cmd;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            idx_q     <= '0;
            avg_out_q <= '0;
            overrun_q <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                hist_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            avg_out_q <= avg_out_d;
            overrun_q <= overrun_d;
            for (int k = 0; k < DEPTH; k++) begin
                hist_q[k] <= hist_d[k];
            end
        end
    end

    assign avg_out  = avg_out_q;
    assign avg_done = (state_q == DONE);
    assign busy     = (state_q != IDLE);
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_pid_avg_filter.sv
module tb_pid_avg_filter;

    localparam int DATA_W     = 12;
    localparam int DEPTH      = 8;
    localparam int LOG2_DEPTH = 3;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic              shift_avg = 1'b0;
    logic              calc_avg = 1'b0;
    logic              clr_hist = 1'b0;
    logic [DATA_W-1:0] error_in = '0;
    logic [DATA_W-1:0] avg_out;
    logic              avg_done;
    logic              busy;
    logic              overrun;

    int n_checks = 0;
    int n_errors = 0;

    pid_avg_filter #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .LOG2_DEPTH(LOG2_DEPTH)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .shift_avg(shift_avg),
        .calc_avg (calc_avg),
        .clr_hist (clr_hist),
        .error_in (error_in),
        .avg_out  (avg_out),
        .avg_done (avg_done),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_rst     = 1'b0;
        shift_avg = 1'b0;
        calc_avg  = 1'b0;
        clr_hist  = 1'b0;
        step();
        step();
        n_rst = 1'b1;
    endtask

    task automatic push(input int val);
        shift_avg = 1'b1;
        error_in  = DATA_W'(val);
        step();
        shift_avg = 1'b0;
    endtask

    // Pulse calc_avg (cycle 0), wait for avg_done with a bounded budget,
    // then check the latency and the result.
    task automatic run_calc(input string tag, input int exp_avg);
        int cyc;
        bit seen;
        calc_avg = 1'b1;
        step();
        calc_avg = 1'b0;
        cyc  = 1;
        seen = 1'b0;
        while (cyc <= 20 && !seen) begin
            if (avg_done) seen = 1'b1;
            else begin
                step();
                cyc++;
            end
        end
        check({tag, "_seen"}, int'(seen), 1);
        check({tag, "_lat"}, cyc, DEPTH + 1);
        check({tag, "_avg"}, int'($signed(avg_out)), exp_avg);
        step();
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_avg", int'($signed(avg_out)), 0);
        check("rst_done", int'(avg_done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ovr", int'(overrun), 0);

        // Empty window: cycle-exact busy/avg_done profile
        calc_avg = 1'b1;
        step();
        calc_avg = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            check($sformatf("prof_busy_c%0d", c), int'(busy), (c <= 9) ? 1 : 0);
            check($sformatf("prof_done_c%0d", c), int'(avg_done), (c == 9) ? 1 : 0);
            check($sformatf("prof_ovr_c%0d", c), int'(overrun), 0);
            step();
        end
        check("prof_avg", int'($signed(avg_out)), 0);

        // Full window of 100, then one newer sample of 900: sum 1600
        for (int i = 0; i < 8; i++) push(100);
        run_calc("avg100", 100);
        push(900);
        run_calc("avg200", 200);

        // Floor behaviour on negative sums
        do_reset();
        push(-8);
        run_calc("neg8", -1);
        do_reset();
        push(-9);
        run_calc("neg9", -2);

        // Extremes do not wrap
        do_reset();
        for (int i = 0; i < 8; i++) push(2047);
        run_calc("max", 2047);
        for (int i = 0; i < 8; i++) push(-2048);
        run_calc("min", -2048);

        // Simultaneous shift+calc, then a dropped shift during SUM
        do_reset();
        shift_avg = 1'b1;
        calc_avg  = 1'b1;
        error_in  = DATA_W'(80);
        step();                         // cycle 1
        shift_avg = 1'b0;
        calc_avg  = 1'b0;
        step();                         // cycle 2
        step();                         // cycle 3
        step();                         // cycle 4
        shift_avg = 1'b1;
        error_in  = DATA_W'(999);
        check("ovr_c4", int'(overrun), 0);
        step();                         // cycle 5
        shift_avg = 1'b0;
        check("ovr_c5", int'(overrun), 1);
        step();                         // cycle 6
        check("ovr_c6", int'(overrun), 0);
        step();                         // cycle 7
        step();                         // cycle 8
        step();                         // cycle 9
        check("both_done_c9", int'(avg_done), 1);
        check("both_avg", int'($signed(avg_out)), 10);
        step();
        run_calc("unchanged", 10);

        // Reset during SUM aborts; window is cleared
        do_reset();
        for (int i = 0; i < 8; i++) push(100);
        run_calc("pre_abort", 100);
        calc_avg = 1'b1;
        step();                         // cycle 1
        calc_avg = 1'b0;
        for (int c = 2; c <= 5; c++) step();
        check("abort_busy_c5", int'(busy), 1);
        n_rst = 1'b0;
        #2;
        check("abort_avg", int'($signed(avg_out)), 0);
        check("abort_busy", int'(busy), 0);
        step();
        n_rst = 1'b1;
        begin
            int done_seen;
            done_seen = 0;
            for (int c = 0; c < 12; c++) begin
                if (avg_done) done_seen = 1;
                step();
            end
            check("abort_no_done", done_seen, 0);
        end
        check("abort_avg_hold", int'($signed(avg_out)), 0);
        run_calc("after_abort", 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
